// File: rtl/mmio_uart_rx.sv
// mmio_uart_rx: memory-mapped 8N1 UART receiver with a byte FIFO.
// DATA register at BASE (read pops the FIFO), STATUS at BASE+4 (W1C sticky flags).
// Optional macro UART_RX_PARITY_EN switches the frame format to 8E1 and enables perr.
module mmio_uart_rx #(
  parameter int          CLK_HZ    = 100000000,
  parameter int          BAUD      = 115200,
  parameter int          FIFO_LOG2 = 4,
  parameter logic [31:0] BASE      = 32'hf0000104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  input  logic        mmio_oe,
  input  logic [3:0]  mmio_we,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        rx_irq
);

  localparam int          CPB     = CLK_HZ / BAUD;
  localparam int          DEPTH   = 1 << FIFO_LOG2;
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
  localparam logic [31:0] STAT_A  = BASE + 32'd4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
`endif

  state_t                 state_q;
  logic                   s1_q, s2_q;
  logic [15:0]            cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic                   par_ok;
  logic [7:0]             mem_q [DEPTH];
  logic [FIFO_LOG2-1:0]   wp_q, rp_q;
  logic [FIFO_LOG2:0]     count_q, count_d;
  logic                   ovr_q, ferr_q, perr_q;
  logic [31:0]            rdata_d;
  logic                   stop_smp, push_ok, do_push, pop, empty, full;
  logic                   rd_data, rd_stat, wr_stat;
  logic                   ovr_set, ferr_set, perr_set;
  wire                    unused_ok = ^{mmio_wdata[31:4], mmio_wdata[0], mmio_we[3:1]};

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= uart_rxd;
      s2_q <= s1_q;
    end
  end

  // Frame FSM: the detection cycle counts as the first tick of the half-bit wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_ok  <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (!s2_q) begin
          bit_q   <= '0;
          cnt_q   <= 16'd1;
          state_q <= S_START;
        end
        S_START: if (cnt_q == HALF_M1) begin
          cnt_q   <= '0;
          state_q <= s2_q ? S_IDLE : S_DATA;  // high again: glitch, no flag
        end else cnt_q <= cnt_q + 16'd1;
        S_DATA: if (cnt_q == CPB_M1) begin
          cnt_q   <= '0;
          shift_q <= {s2_q, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_q <= S_PARITY;
`else
          if (bit_q == 3'd7) state_q <= S_STOP;
`endif
        end else cnt_q <= cnt_q + 16'd1;
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt_q == CPB_M1) begin
          cnt_q   <= '0;
          par_ok  <= ~(^shift_q ^ s2_q);
          state_q <= S_STOP;
        end else cnt_q <= cnt_q + 16'd1;
`endif
        // Leave at mid-stop so a following start edge is not missed.
        S_STOP: if (cnt_q == CPB_M1) begin
          cnt_q   <= '0;
          state_q <= s2_q ? S_IDLE : S_BRK;
        end else cnt_q <= cnt_q + 16'd1;
        // Bad stop bit: hold here until the line idles so a break cannot retrigger.
        S_BRK: if (s2_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_ok = 1'b1;
`endif

  // Frame outcome, MMIO decode and FIFO push/pop arbitration.
  always_comb begin
    stop_smp = (state_q == S_STOP) && (cnt_q == CPB_M1);
    push_ok  = stop_smp && s2_q && par_ok;
    ferr_set = stop_smp && !s2_q;
`ifdef UART_RX_PARITY_EN
    perr_set = stop_smp && !par_ok;
`else
    perr_set = 1'b0;
`endif
    rd_data  = mmio_oe && (mmio_we == 4'b0) && (mmio_addr == BASE);
    rd_stat  = mmio_oe && (mmio_we == 4'b0) && (mmio_addr == STAT_A);
    wr_stat  = mmio_oe && mmio_we[0] && (mmio_addr == STAT_A);
    empty    = (count_q == '0);
    full     = (count_q == (FIFO_LOG2+1)'(DEPTH));
    pop      = rd_data && !empty;            // a same-cycle push is never visible here
    do_push  = push_ok && (!full || pop);
    ovr_set  = push_ok && full && !pop;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    rdata_d  = '0;
    if (pop)          rdata_d = {23'b0, 1'b1, mem_q[rp_q]};
    else if (rd_stat) rdata_d = {28'b0, perr_q, ferr_q, ovr_q, ~empty};
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= shift_q;
  end

  // Pointers, count, sticky flags (set wins over clear) and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      mmio_rdata <= '0;
      rx_irq     <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      count_q    <= count_d;
      ovr_q      <= (ovr_q  & ~(wr_stat & mmio_wdata[1])) | ovr_set;
      ferr_q     <= (ferr_q & ~(wr_stat & mmio_wdata[2])) | ferr_set;
      perr_q     <= (perr_q & ~(wr_stat & mmio_wdata[3])) | perr_set;
      mmio_rdata <= rdata_d;
      rx_irq     <= (count_d != '0);
    end
  end

endmodule

// File: doc/mmio_uart_rx.md
Name: mmio_uart_rx

Overview:
- Memory-mapped UART receiver. The complement of the TX byte port at 0xf0000100.
- Deserializes 8N1 frames from the board `uart_rxd` pin and buffers bytes in a small FIFO.
- Exposes data and status registers on the CPU MMIO bus so firmware can poll-read console input.
- Sits beside the existing MMIO decoder in TOP_NEXYS4DDR.

Parameters:
- CLK_HZ, 100000000, core clock frequency in Hz.
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, must be >= 4.
- FIFO_LOG2, 4, FIFO depth = 2**FIFO_LOG2 bytes.
- BASE, 32'hf0000104, address of the DATA register; STATUS register is at BASE+4.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  serial input, idle high, asynchronous to clk.
- mmio_oe  in  1  MMIO access strobe, one cycle per access.
- mmio_we  in  4  byte write enables; all zero means read.
- mmio_addr  in  32  access address.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  read data, registered.
- rx_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - FIFO pointers = 0, count = 0.
  - Sticky flags (ovr, ferr) = 0.
  - mmio_rdata = 0, rx_irq = 0.
  - Both stages of the 2-FF synchronizer = 1.
- Reset asserted mid-frame aborts the frame and discards FIFO contents.
- Input path: uart_rxd passes through a 2-FF synchronizer. FSM timing counts from the synchronized signal, so there is a 2-cycle input latency.
- FSM:
  - IDLE: when the synchronized line is low, clear the bit counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If still low go to DATA; if high (glitch) return to IDLE with no flag set.
  - DATA: every CLKS_PER_BIT cycles sample one bit, LSB first, into the shift register. After 8 bits go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample.
    - If high: push the byte and return to IDLE.
    - If low: set ferr, drop the byte, and go to IDLE only once the line has returned high. This prevents a break condition from retriggering.
  - The FSM returns to IDLE at mid-stop-bit, so back-to-back frames are received with no gap.
- FIFO:
  - Push occurs in the cycle of the stop sample.
  - Push when full: drop the byte and set ovr.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push and pop in the same cycle while empty: the pushed byte is not visible to the concurrent pop.
  - Pointers wrap modulo 2**FIFO_LOG2; count ranges 0..2**FIFO_LOG2.
- MMIO access is decoded only when mmio_oe=1 and mmio_addr matches exactly; other addresses are ignored and leave mmio_rdata at 0.
- Read DATA (we=0, addr=BASE):
  - Next cycle mmio_rdata = {23'b0, 1'b1, byte}: bit8 = valid, bits 7:0 = the byte.
  - The FIFO is popped in the request cycle.
  - If empty: rdata = 0 and no pointer change.
- Read STATUS (addr=BASE+4): next cycle rdata = {28'b0, perr, ferr, ovr, ~empty}.
- Write STATUS with mmio_we[0]=1: each sticky flag whose wdata bit is 1 is cleared (write-1-to-clear, bits 1..3). A flag set in the same cycle as its clear stays set.
- Writes to DATA are ignored.
- mmio_rdata returns to 0 in any cycle after a non-matching or absent access.
- rx_irq = ~empty, registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frames are 8E1: an even-parity bit is sampled after bit 7 in state PARITY, then the FSM goes to STOP.
  - Parity mismatch sets sticky perr (STATUS bit3) and drops the byte, even if the stop bit is good.
  - If both parity and stop fail, both perr and ferr are set.
- Undefined: the PARITY state does not exist, frames are 8N1, and STATUS bit3 reads 0.

Test Plan:
- All scenarios use CLK_HZ=1000000 and BAUD=100000, so CLKS_PER_BIT=10.
- Single byte: drive frame 0x41 → rx_irq rises within 97 cycles of the start edge. DATA read returns 0x00000141. A second DATA read returns 0x00000000 and rx_irq=0.
- Back-to-back: send 0x55, 0xAA, 0x00 with no idle gap → three DATA reads return 0x155, 0x1AA, 0x100 in order.
- Overrun: send 17 bytes 0x00..0x10 with no reads (FIFO_LOG2=4) → STATUS reads 0x3. DATA reads return 0x100..0x10F, then 0. Writing 0x2 to STATUS then reading it gives 0x0.
- Framing/glitch:
  - A 3-cycle low pulse on idle produces no byte and no flag.
  - Frame 0x7E with low stop bit, line held low 30 more cycles → ferr set, FIFO empty.
  - A following 0x31 frame is received correctly.
- Reset mid-frame: assert rst at the middle of bit 4 with 2 bytes queued → after release, STATUS=0, DATA reads 0. The next full frame 0x5A is received intact.
- Parity (macro defined): 0x03 with parity bit 0 is accepted. 0x03 with parity bit 1 → STATUS bit3=1 and no byte pushed.
